div_radix4_sched: RTL and testbench

- Shares one radix-4 SRT divider instance (24-bit 1.23 mantissa datapath, 12 iterations) between two requesters.
- Round-robin arbitration, operand latching and divider sequencing: reset pulse, clock-enable window, result capture.
- Result returned with a valid/ready handshake to the requester that issued the operation.
- Sits between the FP-divide front ends (exponent/sign paths) and the mantissa divider.

---
 rtl/div_radix4_sched.sv | 220 ++++++++++++++++++++++
 tb/tb_div_radix4_sched.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_radix4_sched.sv
// Two-requester scheduler in front of one shared radix-4 SRT mantissa divider.
// Arbitrates round-robin, latches the winner's operands, runs the divider
// through a clear / clock-enable window and returns the quotient to the
// requester that issued the operation over a valid/ready channel.
module div_radix4_sched #(
  parameter int WL      = 24,  // operand/quotient word length, 1.(WL-1) format
  parameter int N       = 12,  // divider iteration count
  parameter int DIV_LAT = 13,  // div_ce-high cycles until div_dout is sampled
  parameter int CW      = 4    // iteration counter width
) (
  input  logic          CLK,
  input  logic          nRST,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [WL-1:0] req0_x,
  input  logic [WL-1:0] req0_d,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [WL-1:0] req1_x,
  input  logic [WL-1:0] req1_d,
  output logic          rsp0_valid,
  input  logic          rsp0_ready,
  output logic          rsp1_valid,
  input  logic          rsp1_ready,
  output logic [WL-1:0] rsp_q,
  output logic          rsp_err,
  output logic          div_nrst,
  output logic          div_ce,
  output logic [WL-1:0] div_x,
  output logic [WL-1:0] div_d,
  input  logic [WL-1:0] div_dout,
  output logic          busy
);

  // The divider latency is its iteration count plus its output register, and
  // the counter must be able to reach the last RUN index.
  if ((DIV_LAT != N + 1) || ((1 << CW) <= DIV_LAT)) begin : g_param_chk
    $error("div_radix4_sched: inconsistent N/DIV_LAT/CW");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CLR  = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // A divisor is only legal for the SRT divider when its leading bit is set.
  function automatic logic f_divisor_normalized(input logic [WL-1:0] d);
    return d[WL-1];
  endfunction

  state_t        r_state;
  state_t        w_state_nxt;

  logic          r_rr_last;
  logic          r_owner;
  logic          r_err;
  logic [CW-1:0] r_cnt;
  logic [WL-1:0] r_x;
  logic [WL-1:0] r_d;
  logic [WL-1:0] r_q;

  logic          r_div_nrst;
  logic          r_div_ce;
  logic          r_rsp0_valid;
  logic          r_rsp1_valid;
  logic          r_busy;

  logic          w_grant;
  logic          w_gnt_owner;
  logic          w_owner_nxt;
  logic [WL-1:0] w_gnt_x;
  logic [WL-1:0] w_gnt_d;
  logic          w_run_last;
  logic          w_rsp_take;
  logic          w_req0_ready;
  logic          w_req1_ready;

  assign w_grant     = (r_state == S_IDLE) && (req0_valid || req1_valid);
  assign w_gnt_x     = w_gnt_owner ? req1_x : req0_x;
  assign w_gnt_d     = w_gnt_owner ? req1_d : req0_d;
  assign w_owner_nxt = w_grant ? w_gnt_owner : r_owner;
  assign w_run_last  = (r_cnt == CW'(DIV_LAT - 1));
  assign w_rsp_take  = r_owner ? rsp1_ready : rsp0_ready;

  // Round-robin pick: a lone requester wins, a tie goes to the one not served last.
  always_comb begin
    w_gnt_owner = 1'b0;
    if (req0_valid && req1_valid) begin
      w_gnt_owner = ~r_rr_last;
    end else if (req1_valid) begin
      w_gnt_owner = 1'b1;
    end else begin
      w_gnt_owner = 1'b0;
    end
  end

  // Next-state logic and the combinational accept strobe for the winner.
  always_comb begin
    w_state_nxt  = r_state;
    w_req0_ready = 1'b0;
    w_req1_ready = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_grant) begin
          w_req0_ready = ~w_gnt_owner;
          w_req1_ready = w_gnt_owner;
          if (f_divisor_normalized(w_gnt_d)) begin
            w_state_nxt = S_CLR;
          end else begin
            w_state_nxt = S_DONE;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_CLR: begin
        w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (w_run_last) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_RUN;
        end
      end
      S_DONE: begin
        if (w_rsp_take) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_DONE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Control outputs are registered from the next state so they line up with it.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_div_nrst   <= 1'b0;
      r_div_ce     <= 1'b0;
      r_rsp0_valid <= 1'b0;
      r_rsp1_valid <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_div_nrst   <= (w_state_nxt == S_RUN) || (w_state_nxt == S_DONE);
      r_div_ce     <= (w_state_nxt == S_RUN);
      r_rsp0_valid <= (w_state_nxt == S_DONE) && !w_owner_nxt;
      r_rsp1_valid <= (w_state_nxt == S_DONE) && w_owner_nxt;
      r_busy       <= (w_state_nxt != S_IDLE);
    end
  end

  // Operand latch on grant, iteration counting and quotient capture.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_rr_last <= 1'b1;
      r_owner   <= 1'b0;
      r_err     <= 1'b0;
      r_cnt     <= '0;
      r_x       <= '0;
      r_d       <= '0;
      r_q       <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant) begin
            r_x       <= w_gnt_x;
            r_d       <= w_gnt_d;
            r_owner   <= w_gnt_owner;
            r_rr_last <= w_gnt_owner;
            if (!f_divisor_normalized(w_gnt_d)) begin
              r_q   <= '0;
              r_err <= 1'b1;
            end
          end
        end
        S_CLR: begin
          r_cnt <= '0;
        end
        S_RUN: begin
          r_cnt <= r_cnt + CW'(1);
          if (w_run_last) begin
            r_q   <= div_dout;
            r_err <= 1'b0;
          end
        end
        default: begin
          r_cnt <= r_cnt;
        end
      endcase
    end
  end

  assign req0_ready = w_req0_ready;
  assign req1_ready = w_req1_ready;
  assign rsp0_valid = r_rsp0_valid;
  assign rsp1_valid = r_rsp1_valid;
  assign rsp_q      = r_q;
  assign rsp_err    = r_err;
  assign div_nrst   = r_div_nrst;
  assign div_ce     = r_div_ce;
  assign div_x      = r_x;
  assign div_d      = r_d;
  assign busy       = r_busy;

endmodule

// File: tb/tb_div_radix4_sched.sv
// Self-checking bench for div_radix4_sched: a divider stand-in drives
// div_dout, a small arithmetic reference predicts quotients and arbitration.
module tb_div_radix4_sched;
  localparam int WL = 24;

  logic          CLK = 1'b0;
  logic          nRST;
  logic          req0_valid, req0_ready, req1_valid, req1_ready;
  logic [WL-1:0] req0_x, req0_d, req1_x, req1_d;
  logic          rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [WL-1:0] rsp_q;
  logic          rsp_err, div_nrst, div_ce, busy;
  logic [WL-1:0] div_x, div_d, div_dout;

  int n_tests = 0;
  int n_fail  = 0;
  int m_last  = 1;  // model of the last granted requester

  div_radix4_sched dut (
    .CLK(CLK), .nRST(nRST),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_x(req0_x), .req0_d(req0_d),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_x(req1_x), .req1_d(req1_d),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_q(rsp_q), .rsp_err(rsp_err),
    .div_nrst(div_nrst), .div_ce(div_ce), .div_x(div_x), .div_d(div_d),
    .div_dout(div_dout), .busy(busy)
  );

  always #5 CLK = ~CLK;

  // Reference quotient in 1.23 fixed point: x / d, truncated.
  function automatic logic [WL-1:0] ref_q(input logic [WL-1:0] x, input logic [WL-1:0] d);
    logic [47:0] num;
    if (d[WL-1] == 1'b0) return '0;
    num = 48'(x) << (WL - 1);
    return WL'(num / 48'(d));
  endfunction

  function automatic logic ref_err(input logic [WL-1:0] d);
    return ~d[WL-1];
  endfunction

  // Divider stand-in: result is only correct on the 13th enabled cycle after a clear.
  logic [4:0] s_cnt;
  always @(posedge CLK) begin
    if (!div_nrst) s_cnt <= 5'd0;
    else if (div_ce) s_cnt <= s_cnt + 5'd1;
  end
  assign div_dout = (s_cnt == 5'd12) ? ref_q(div_x, div_d) : 24'h5A5A5A;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Wait (bounded) for an accept strobe and check who got it.
  task automatic wait_grant(input int exp, input bit at_neg);
    bit seen;
    seen = 1'b0;
    if (!at_neg) @(negedge CLK);
    for (int k = 0; k < 40; k++) begin
      if (req0_ready || req1_ready) begin
        seen = 1'b1;
        break;
      end
      @(negedge CLK);
    end
    chk("grant_seen", 32'(seen), 32'd1);
    chk("grant_id", {30'd0, req1_ready, req0_ready}, (exp == 1) ? 32'd2 : 32'd1);
    m_last = exp;
  endtask

  // From the accept cycle, wait for the response and check latency, window and data.
  task automatic wait_rsp(input int own, input logic [WL-1:0] eq, input logic ee,
                          input int elat, input logic [WL-1:0] ex, input logic [WL-1:0] ed);
    int lat, ce;
    bit seen, stab, nordy;
    lat = 0; ce = 0; seen = 1'b0; stab = 1'b1; nordy = 1'b1;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge CLK);
      lat++;
      if (div_ce) ce++;
      if (div_x !== ex || div_d !== ed) stab = 1'b0;
      if (req0_ready || req1_ready) nordy = 1'b0;
      if (rsp0_valid || rsp1_valid) seen = 1'b1;
    end
    chk("rsp_latency", 32'(lat), 32'(elat));
    chk("ce_window", 32'(ce), ee ? 32'd0 : 32'd13);
    chk("operands_stable", 32'(stab), 32'd1);
    chk("ready_low_busy", 32'(nordy), 32'd1);
    chk("rsp_id", {30'd0, rsp1_valid, rsp0_valid}, (own == 1) ? 32'd2 : 32'd1);
    chk("rsp_q", 32'(rsp_q), 32'(eq));
    chk("rsp_err", 32'(rsp_err), 32'(ee));
    chk("done_busy_nrst", {30'd0, busy, div_nrst}, 32'd3);
  endtask

  // Optionally hold off the response, then accept it and check it retires.
  task automatic ack(input int own, input int hold, input logic [WL-1:0] eq);
    bit ok;
    ok = 1'b1;
    for (int h = 0; h < hold; h++) begin
      @(negedge CLK);
      if (rsp_q !== eq || {rsp1_valid, rsp0_valid} !== ((own == 1) ? 2'd2 : 2'd1) ||
          !busy || req0_ready || req1_ready) ok = 1'b0;
    end
    if (hold > 0) chk("hold_stable", 32'(ok), 32'd1);
    @(posedge CLK); #1;
    if (own == 1) rsp1_ready = 1'b1; else rsp0_ready = 1'b1;
    @(posedge CLK); #1;
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
    @(negedge CLK);
    chk("rsp_drop", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
  endtask

  typedef struct {
    logic [WL-1:0] x;
    logic [WL-1:0] d;
    logic [WL-1:0] q;
    logic          err;
  } vec_t;

  vec_t vt[9];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WL-1:0] x0, d0, x1, d1, ex, ed;
    int v0, v1, exp;
    bit ok;

    vt[0] = '{24'h800000, 24'h800000, 24'h800000, 1'b0};
    vt[1] = '{24'hC00000, 24'h800000, 24'hC00000, 1'b0};
    vt[2] = '{24'h800000, 24'hC00000, 24'h555555, 1'b0};
    vt[3] = '{24'hFFFFFF, 24'h800000, 24'hFFFFFF, 1'b0};
    vt[4] = '{24'h800000, 24'hFFFFFF, 24'h400000, 1'b0};
    vt[5] = '{24'hC00000, 24'hC00000, 24'h800000, 1'b0};
    vt[6] = '{24'hA00000, 24'hA00000, 24'h800000, 1'b0};
    vt[7] = '{24'h800000, 24'h400000, 24'h000000, 1'b1};
    vt[8] = '{24'h123456, 24'h000000, 24'h000000, 1'b1};

    nRST = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_x = '0; req0_d = '0; req1_x = '0; req1_d = '0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    repeat (3) @(negedge CLK);
    chk("rst_ctl", {27'd0, div_nrst, div_ce, busy, rsp1_valid, rsp0_valid}, 32'd0);
    chk("rst_data", {7'd0, rsp_err, rsp_q}, 32'd0);
    chk("rst_ops", 32'(div_x | div_d), 32'd0);
    nRST = 1'b1;

    // Round-robin with both requesters continuously valid: 0,1,0,1,...
    @(posedge CLK); #1;
    req0_valid = 1'b1; req0_x = 24'hC00000; req0_d = 24'h800000;
    req1_valid = 1'b1; req1_x = 24'hC00000; req1_d = 24'h800000;
    for (int i = 0; i < 8; i++) begin
      exp = 1 - m_last;
      chk("rr_order", 32'(exp), 32'(i % 2));
      wait_grant(exp, i > 0);
      if (i >= 6) begin
        @(posedge CLK); #1;
        if (exp == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
      end
      wait_rsp(exp, 24'hC00000, 1'b0, 15, 24'hC00000, 24'h800000);
      ack(exp, 0, 24'hC00000);
    end

    // Table-driven single ops on requester 0.
    for (int i = 0; i < 9; i++) begin
      @(posedge CLK); #1;
      req0_valid = 1'b1; req0_x = vt[i].x; req0_d = vt[i].d;
      wait_grant(0, 1'b0);
      @(posedge CLK); #1;
      req0_valid = 1'b0;
      wait_rsp(0, vt[i].q, vt[i].err, vt[i].err ? 1 : 15, vt[i].x, vt[i].d);
      ack(0, 0, vt[i].q);
    end

    // Unnormalized divisor on requester 1.
    @(posedge CLK); #1;
    req1_valid = 1'b1; req1_x = 24'h800000; req1_d = 24'h400000;
    wait_grant(1, 1'b0);
    @(posedge CLK); #1;
    req1_valid = 1'b0;
    wait_rsp(1, 24'h000000, 1'b1, 1, 24'h800000, 24'h400000);
    ack(1, 0, 24'h000000);

    // Backpressure: hold the req0 response 20 cycles while req1 waits.
    @(posedge CLK); #1;
    req0_valid = 1'b1; req0_x = 24'hFFFFFF; req0_d = 24'h800000;
    wait_grant(0, 1'b0);
    @(posedge CLK); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_x = 24'h800000; req1_d = 24'hC00000;
    wait_rsp(0, 24'hFFFFFF, 1'b0, 15, 24'hFFFFFF, 24'h800000);
    ack(0, 20, 24'hFFFFFF);
    chk("bp_req1_next", {30'd0, req1_ready, req0_ready}, 32'd2);
    m_last = 1;
    @(posedge CLK); #1;
    req1_valid = 1'b0;
    wait_rsp(1, 24'h555555, 1'b0, 15, 24'h800000, 24'hC00000);
    ack(1, 0, 24'h555555);

    // Reset in the middle of RUN (counter 5), then a clean op.
    @(posedge CLK); #1;
    req0_valid = 1'b1; req0_x = 24'hC00000; req0_d = 24'h800000;
    wait_grant(0, 1'b0);
    @(posedge CLK); #1;
    req0_valid = 1'b0;
    repeat (6) @(posedge CLK);
    #1;
    chk("pre_rst_ce", 32'(div_ce), 32'd1);
    #1;
    nRST = 1'b0;
    #1;
    chk("midrst_ctl", {27'd0, div_nrst, div_ce, busy, rsp1_valid, rsp0_valid}, 32'd0);
    chk("midrst_ops", 32'(div_x | div_d), 32'd0);
    m_last = 1;
    ok = 1'b1;
    repeat (3) begin
      @(negedge CLK);
      if (rsp0_valid || rsp1_valid || div_nrst || busy) ok = 1'b0;
    end
    chk("midrst_hold", 32'(ok), 32'd1);
    nRST = 1'b1;
    @(posedge CLK); #1;
    req0_valid = 1'b1; req0_x = 24'h800000; req0_d = 24'h800000;
    wait_grant(0, 1'b0);
    @(posedge CLK); #1;
    req0_valid = 1'b0;
    wait_rsp(0, 24'h800000, 1'b0, 15, 24'h800000, 24'h800000);
    ack(0, 0, 24'h800000);

    // Randomized ops against the arithmetic and round-robin reference.
    for (int i = 0; i < 40; i++) begin
      @(posedge CLK); #1;
      v0 = int'($urandom_range(0, 1));
      v1 = int'($urandom_range(0, 1));
      if (v0 == 0 && v1 == 0) v0 = 1;
      x0 = 24'($urandom); d0 = 24'($urandom);
      x1 = 24'($urandom); d1 = 24'($urandom);
      if ($urandom_range(0, 7) != 0) d0[WL-1] = 1'b1;
      if ($urandom_range(0, 7) != 0) d1[WL-1] = 1'b1;
      req0_valid = (v0 == 1); req0_x = x0; req0_d = d0;
      req1_valid = (v1 == 1); req1_x = x1; req1_d = d1;
      exp = (v0 == 1 && v1 == 1) ? (1 - m_last) : v1;
      ex  = (exp == 1) ? x1 : x0;
      ed  = (exp == 1) ? d1 : d0;
      wait_grant(exp, 1'b0);
      @(posedge CLK); #1;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      wait_rsp(exp, ref_q(ex, ed), ref_err(ed), ref_err(ed) ? 1 : 15, ex, ed);
      ack(exp, int'($urandom_range(0, 3)), ref_q(ex, ed));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
